// File: rtl/jtkcpu_irq_pkg.sv
// KCPU interrupt sequencer shared definitions: one-hot source codes,
// sequencer states and the NMI > FIRQ > IRQ priority pick.
package jtkcpu_irq_pkg;

    localparam logic [3:0] INT_NONE = 4'b0000;
    localparam logic [3:0] INT_RST  = 4'b1000;
    localparam logic [3:0] INT_NMI  = 4'b0100;
    localparam logic [3:0] INT_FIRQ = 4'b0010;
    localparam logic [3:0] INT_IRQ  = 4'b0001;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_ENTRY  = 2'd1,
        IRQ_VECTOR = 2'd2
    } irq_state_t;

    function automatic logic [3:0] irq_pick(
        input logic nmi,
        input logic firq,
        input logic irq
    );
        logic [3:0] sel;
        sel = INT_NONE;
        priority case (1'b1)
            nmi:     sel = INT_NMI;
            firq:    sel = INT_FIRQ;
            irq:     sel = INT_IRQ;
            default: sel = INT_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtkcpu_irqsync.sv
// Two-stage synchronizer for the NMI/FIRQ/IRQ pins, used only when
// JTKCPU_IRQSYNC_EN is defined. Free-running on clk, resets to idle-high.
module jtkcpu_irqsync (
    input  logic       rst,
    input  logic       clk,
    input  logic [2:0] i_din,
    output logic [2:0] o_dout
);

    logic [2:0] r_s1;
    logic [2:0] r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 3'b111;
            r_s2 <= 3'b111;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
        end
    end

    assign o_dout = r_s2;

endmodule

// File: rtl/jtkcpu_irqctl.sv
// KCPU interrupt sequencer: NMI edge capture, FIRQ/IRQ masking, priority,
// entry/vector handshake. Define JTKCPU_IRQSYNC_EN to synchronize the pins.
module jtkcpu_irqctl
    import jtkcpu_irq_pkg::*;
#(
    parameter bit NMI_ARM_RST = 1'b0
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       nmi_n,
    input  logic       firq_n,
    input  logic       irq_n,
    input  logic       cc_i,
    input  logic       cc_f,
    input  logic       ni,
    input  logic       int_en,
    input  logic       nmi_arm,
    input  logic       set_fake,
    output logic       take,
    output logic [3:0] cur_int,
    output logic [3:0] intvec,
    output logic       intsrv,
    output logic       irq_bsy
);

    logic       w_nmi_n;
    logic       w_firq_n;
    logic       w_irq_n;

`ifdef JTKCPU_IRQSYNC_EN
    logic [2:0] w_sync;

    jtkcpu_irqsync u_sync (
        .rst    (rst),
        .clk    (clk),
        .i_din  ({nmi_n, firq_n, irq_n}),
        .o_dout (w_sync)
    );

    assign {w_nmi_n, w_firq_n, w_irq_n} = w_sync;
`else
    assign {w_nmi_n, w_firq_n, w_irq_n} = {nmi_n, firq_n, irq_n};
`endif

    irq_state_t r_state;
    irq_state_t w_nxt_state;
    logic [3:0] r_cur_int;
    logic [3:0] w_nxt_cur;
    logic       r_take;
    logic       w_nxt_take;
    logic       r_bsy;
    logic       w_nxt_bsy;
    logic       w_clr_nmi;
    logic       w_clr_fake;

    logic       r_nmi_l;
    logic       r_nmi_armed;
    logic       r_nmi_pend;
    logic       r_fake;

    logic       w_nmi_edge;
    logic       w_firq_req;
    logic       w_irq_req;
    logic       w_intsrv;
    logic [3:0] w_pick;

    // An edge seen while unarmed is lost; arming only counts from next cycle
    assign w_nmi_edge = !w_nmi_n && r_nmi_l && r_nmi_armed;
    assign w_firq_req = !w_firq_n && !cc_f;
    assign w_irq_req  = (!w_irq_n || r_fake) && !cc_i;
    assign w_intsrv   = r_nmi_pend || w_firq_req || w_irq_req;
    assign w_pick     = irq_pick(r_nmi_pend, w_firq_req, w_irq_req);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cur   = r_cur_int;
        w_nxt_take  = 1'b0;
        w_nxt_bsy   = r_bsy;
        w_clr_nmi   = 1'b0;
        w_clr_fake  = 1'b0;
        unique case (r_state)
            IRQ_IDLE: begin
                if (ni) begin
                    if (w_intsrv) begin
                        w_nxt_state = IRQ_ENTRY;
                        w_nxt_cur   = w_pick;
                        w_nxt_take  = 1'b1;
                        w_nxt_bsy   = 1'b1;
                        w_clr_nmi   = (w_pick == INT_NMI);
                        w_clr_fake  = (w_pick == INT_IRQ);
                    end else begin
                        w_nxt_cur = INT_NONE;
                    end
                end
            end
            IRQ_ENTRY: begin
                if (int_en) begin
                    w_nxt_state = IRQ_VECTOR;
                end
            end
            IRQ_VECTOR: begin
                if (!int_en) begin
                    w_nxt_state = IRQ_IDLE;
                    w_nxt_cur   = INT_NONE;
                    w_nxt_bsy   = 1'b0;
                end
            end
            default: begin
                w_nxt_state = IRQ_IDLE;
                w_nxt_cur   = INT_NONE;
                w_nxt_bsy   = 1'b0;
            end
        endcase
    end

    // Reset enters the same ENTRY->VECTOR path with the reset vector selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IRQ_ENTRY;
            r_cur_int <= INT_RST;
            r_take    <= 1'b0;
            r_bsy     <= 1'b0;
        end else if (cen) begin
            r_state   <= w_nxt_state;
            r_cur_int <= w_nxt_cur;
            r_take    <= w_nxt_take;
            r_bsy     <= w_nxt_bsy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_l     <= 1'b1;
            r_nmi_armed <= NMI_ARM_RST;
            r_nmi_pend  <= 1'b0;
            r_fake      <= 1'b0;
        end else if (cen) begin
            r_nmi_l <= w_nmi_n;
            if (nmi_arm) begin
                r_nmi_armed <= 1'b1;
            end
            if (w_nmi_edge) begin
                r_nmi_pend <= 1'b1;
            end else if (w_clr_nmi) begin
                r_nmi_pend <= 1'b0;
            end
            if (set_fake) begin
                r_fake <= 1'b1;
            end else if (w_clr_fake) begin
                r_fake <= 1'b0;
            end
        end
    end

    assign take    = r_take;
    assign cur_int = r_cur_int;
    assign irq_bsy = r_bsy;
    assign intsrv  = w_intsrv;
    assign intvec  = r_cur_int & {4{int_en}};

endmodule

// File: tb/tb_jtkcpu_irqctl.sv
// Self-checking bench for jtkcpu_irqctl (default build, pins unsynchronized):
// directed scenarios followed by a randomized run against a behavioural model.
module tb_jtkcpu_irqctl;

    logic       rst, clk, cen;
    logic       nmi_n, firq_n, irq_n, cc_i, cc_f;
    logic       ni, int_en, nmi_arm, set_fake;
    logic       take, intsrv, irq_bsy;
    logic [3:0] cur_int, intvec;

    int n_chk = 0;
    int n_err = 0;

    jtkcpu_irqctl #(.NMI_ARM_RST(1'b0)) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .nmi_n    (nmi_n),
        .firq_n   (firq_n),
        .irq_n    (irq_n),
        .cc_i     (cc_i),
        .cc_f     (cc_f),
        .ni       (ni),
        .int_en   (int_en),
        .nmi_arm  (nmi_arm),
        .set_fake (set_fake),
        .take     (take),
        .cur_int  (cur_int),
        .intvec   (intvec),
        .intsrv   (intsrv),
        .irq_bsy  (irq_bsy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase of the service sequence, pending flags, selected source
    localparam int PH_FREE  = 0;
    localparam int PH_STACK = 1;
    localparam int PH_FETCH = 2;

    int       m_phase;
    bit       m_nmi_l, m_armed, m_pend, m_fake, m_take, m_bsy;
    bit [3:0] m_cur;

    function automatic bit m_firq();
        return !firq_n && !cc_f;
    endfunction

    function automatic bit m_irq();
        return (!irq_n || m_fake) && !cc_i;
    endfunction

    function automatic bit m_srv();
        return m_pend || m_firq() || m_irq();
    endfunction

    task automatic model_reset();
        m_phase = PH_STACK;
        m_cur   = 4'b1000;
        m_take  = 0;
        m_bsy   = 0;
        m_nmi_l = 1;
        m_armed = 0;
        m_pend  = 0;
        m_fake  = 0;
    endtask

    task automatic model_step();
        bit       edge_seen, clr_nmi, clr_fake;
        int       src;
        if (rst) begin
            model_reset();
            return;
        end
        if (!cen) return;
        edge_seen = !nmi_n && m_nmi_l && m_armed;
        clr_nmi  = 0;
        clr_fake = 0;
        m_take   = 0;
        if (m_phase == PH_FREE && ni) begin
            if (m_srv()) begin
                src = m_pend ? 2 : (m_firq() ? 1 : 0);
                m_cur   = 4'(1 << src);
                m_take  = 1;
                m_bsy   = 1;
                m_phase = PH_STACK;
                clr_nmi  = (src == 2);
                clr_fake = (src == 0);
            end else begin
                m_cur = 0;
            end
        end else if (m_phase == PH_STACK && int_en) begin
            m_phase = PH_FETCH;
        end else if (m_phase == PH_FETCH && !int_en) begin
            m_phase = PH_FREE;
            m_cur   = 0;
            m_bsy   = 0;
        end
        m_pend  = edge_seen ? 1'b1 : (m_pend && !clr_nmi);
        m_fake  = set_fake ? 1'b1 : (m_fake && !clr_fake);
        m_armed = m_armed || nmi_arm;
        m_nmi_l = nmi_n;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Compare at negedge, then let the DUT and model take the posedge
    task automatic cyc();
        @(negedge clk);
        chk("take", take, m_take);
        chk("cur_int", cur_int, m_cur);
        chk("intvec", intvec, m_cur & {4{int_en}});
        chk("intsrv", intsrv, m_srv());
        chk("irq_bsy", irq_bsy, m_bsy);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic service(input logic [3:0] code);
        ni = 0;
        int_en = 1;
        cyc();
        chk("svc_intvec", intvec, code);
        int_en = 0;
        cyc();
        chk("svc_bsy", irq_bsy, 0);
        chk("svc_cur", cur_int, 0);
    endtask

    initial begin
        rst = 1; cen = 1; nmi_n = 1; firq_n = 1; irq_n = 1;
        cc_i = 0; cc_f = 0; ni = 0; int_en = 0; nmi_arm = 0; set_fake = 0;
        model_reset();
        #1;
        chk("rst_cur", cur_int, 4'b1000);
        chk("rst_take", take, 0);
        chk("rst_bsy", irq_bsy, 0);
        cyc();
        rst = 0;
        cyc();
        service(4'b1000);

        // NMI while unarmed is dropped
        nmi_n = 0;
        cyc();
        ni = 1;
        cyc();
        cyc();
        chk("unarmed_take", take, 0);
        ni = 0; nmi_n = 1;
        cyc();
        nmi_arm = 1;
        cyc();
        nmi_arm = 0; nmi_n = 0;
        cyc();
        ni = 1;
        cyc();
        chk("nmi_take", take, 1);
        chk("nmi_cur", cur_int, 4'b0100);
        ni = 0; nmi_n = 1;
        #1;
        chk("nmi_cleared", intsrv, 0);
        service(4'b0100);

        // FIRQ beats IRQ; masking FIRQ exposes IRQ
        firq_n = 0; irq_n = 0; ni = 1;
        cyc();
        chk("firq_cur", cur_int, 4'b0010);
        service(4'b0010);
        cc_f = 1; ni = 1;
        cyc();
        chk("irq_cur", cur_int, 4'b0001);
        service(4'b0001);
        firq_n = 1; cc_f = 0; cc_i = 1; ni = 1;
        cyc();
        chk("masked_srv", intsrv, 0);
        chk("masked_take", take, 0);
        cc_i = 0;
        cyc();
        chk("unmask_take", take, 1);
        chk("unmask_cur", cur_int, 4'b0001);
        irq_n = 1;
        service(4'b0001);

        // BSWI fake IRQ
        set_fake = 1;
        cyc();
        set_fake = 0;
        #1;
        chk("fake_srv", intsrv, 1);
        ni = 1;
        cyc();
        chk("fake_take", take, 1);
        chk("fake_cur", cur_int, 4'b0001);
        ni = 0;
        #1;
        chk("fake_clr", intsrv, 0);
        service(4'b0001);
        set_fake = 1; ni = 1;
        cyc();
        chk("fake_ni_same", take, 0);
        set_fake = 0;
        cyc();
        chk("fake_ni_next", take, 1);
        service(4'b0001);

        // NMI edge coincident with ni, then reset during ENTRY
        nmi_arm = 1;
        cyc();
        nmi_arm = 0; nmi_n = 0; ni = 1;
        cyc();
        chk("nmi_ni_same", take, 0);
        cyc();
        chk("nmi_ni_next", take, 1);
        chk("nmi_ni_cur", cur_int, 4'b0100);
        ni = 0; nmi_n = 1;
        cyc();
        nmi_n = 0;
        cyc();
        rst = 1;
        model_reset();
        #1;
        chk("midrst_cur", cur_int, 4'b1000);
        chk("midrst_bsy", irq_bsy, 0);
        cyc();
        rst = 0; nmi_n = 1;
        cyc();
        chk("midrst_pend", intsrv, 0);
        service(4'b1000);

        for (int i = 0; i < 3000; i++) begin
            cen = ($urandom_range(7) != 0);
            ni = ($urandom_range(2) == 0);
            if (m_phase != PH_FREE) int_en = ($urandom_range(3) != 0);
            else int_en = ($urandom_range(9) == 0);
            if ($urandom_range(5) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(7) == 0) firq_n = ~firq_n;
            if ($urandom_range(7) == 0) irq_n = ~irq_n;
            if ($urandom_range(5) == 0) cc_i = ~cc_i;
            if ($urandom_range(5) == 0) cc_f = ~cc_f;
            set_fake = ($urandom_range(15) == 0);
            nmi_arm = ($urandom_range(40) == 0);
            rst = ($urandom_range(300) == 0);
            if (rst) model_reset();
            cyc();
        end
        rst = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
